// File: rtl/grid_arb_pkg.sv
// Shared opcode encodings, empty-cell marker and FSM state type for the grid RAM arbiter.
package grid_arb_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLAIM = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EVAL,
    S_ACK
  } state_e;

  localparam int EMPTY_CELL = -1;

  // The unused encoding 2'b11 behaves as a plain read.
  function automatic op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'd1:    return OP_WRITE;
      2'd2:    return OP_CLAIM;
      default: return OP_READ;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: grants the first set req bit at or above ptr, wrapping.
// Zero latency; grant is all-zero when no request is pending.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic [PTR_W:0] pos;
  logic           found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < NREQ; i++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(i);
      if (pos >= (PTR_W+1)'(NREQ)) pos = pos - (PTR_W+1)'(NREQ);
      if (!found && req[pos[PTR_W-1:0]]) begin
        grant[pos[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_arbiter.sv
// Serializes READ/WRITE/CLAIM from NREQ placer engines onto one grid RAM; ack after 2 (WRITE) or 4 (READ/CLAIM) cycles.
// Requesters hold req until ack; define GRID_ARB_BOUNDS_EN to reject addresses >= GRID_CELLS with err.
module grid_arbiter
  import grid_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int GRID_CELLS = 49
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [2*NREQ-1:0]        op,
  input  logic [ADDR_W*NREQ-1:0]   addr,
  input  logic [DATA_W*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     claim_ok,
  output logic                     busy,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
`ifdef GRID_ARB_BOUNDS_EN
  ,
  output logic                     err
`endif
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e             state;
  op_e                cur_op;
  op_e                sel_op;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    gnt_q;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gid;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [1:0]         sel_op_raw;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               oob;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    gid        = '0;
    sel_op_raw = '0;
    sel_addr   = '0;
    sel_wdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gid        = PTR_W'(i);
        sel_op_raw = op[2*i +: 2];
        sel_addr   = addr[ADDR_W*i +: ADDR_W];
        sel_wdata  = wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  assign sel_op  = decode_op(sel_op_raw);
  assign ptr_nxt = (gid == PTR_W'(NREQ-1)) ? '0 : gid + PTR_W'(1);

`ifdef GRID_ARB_BOUNDS_EN
  assign oob = (int'(sel_addr) >= GRID_CELLS);
`else
  assign oob = 1'b0;
`endif

  // mem_addr/mem_wdata double as the latched request, so a requester changing its inputs mid-op has no effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_op    <= OP_READ;
      gnt_q     <= '0;
      ptr       <= '0;
      ack       <= '0;
      rdata     <= '0;
      claim_ok  <= 1'b0;
      busy      <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef GRID_ARB_BOUNDS_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            gnt_q     <= grant;
            cur_op    <= sel_op;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            ptr       <= ptr_nxt;
            claim_ok  <= 1'b0;
            busy      <= 1'b1;
`ifdef GRID_ARB_BOUNDS_EN
            err       <= oob;
`endif
            if (oob) begin
              state <= S_ACK;
              ack   <= grant;
              rdata <= '0;
            end else begin
              state  <= S_ISSUE;
              mem_we <= (sel_op == OP_WRITE);
              mem_re <= (sel_op != OP_WRITE);
            end
          end
        end

        S_ISSUE: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          if (cur_op == OP_WRITE) begin
            state <= S_ACK;
            ack   <= gnt_q;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          rdata <= mem_rdata;
          state <= S_EVAL;
          // Claim write is armed here so mem_we is a registered strobe during EVAL.
          if (cur_op == OP_CLAIM && mem_rdata == DATA_W'(EMPTY_CELL)) begin
            mem_we   <= 1'b1;
            claim_ok <= 1'b1;
          end
        end

        S_EVAL: begin
          mem_we <= 1'b0;
          state  <= S_ACK;
          ack    <= gnt_q;
        end

        S_ACK: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_arbiter.sv
// Directed bench for grid_arbiter: a transaction-level model predicts every cycle's outputs; literal checks pin key scenarios.
module tb_grid_arbiter;

  localparam int NREQ       = 4;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;
  localparam int GRID_CELLS = 49;
  localparam logic [DATA_W-1:0] EMPTY = 32'hFFFF_FFFF;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [2*NREQ-1:0]      op = '0;
  logic [ADDR_W*NREQ-1:0] addr = '0;
  logic [DATA_W*NREQ-1:0] wdata = '0;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rdata;
  logic                   claim_ok, busy, mem_re, mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata = '0;
`ifdef GRID_ARB_BOUNDS_EN
  logic                   err;
`endif

  grid_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GRID_CELLS(GRID_CELLS)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .claim_ok(claim_ok), .busy(busy),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef GRID_ARB_BOUNDS_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // Grid RAM with one-cycle read latency, every cell starts empty.
  logic [DATA_W-1:0] ram [64] = '{default: 32'hFFFF_FFFF};
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Transaction-level model: one op at a time, effects applied at completion.
  bit                m_act = 1'b0;
  int                m_start, m_lat, m_id, m_op;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data, m_rd;
  bit                m_ok, m_oob;
  int                mptr = 0;
  logic [DATA_W-1:0] gmem [64] = '{default: 32'hFFFF_FFFF};

  bit                ack_seen [NREQ];
  int                ack_cyc  [NREQ];
  logic [DATA_W-1:0] ack_rd   [NREQ];
  logic              ack_ok   [NREQ];
  int                gorder [$];
  bit                hold_all = 1'b0;
  int                we_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_grant();
    bit found;
    int j;
    found = 1'b0;
    if (!reset && req != '0 && (!m_act || cyc > m_start + m_lat)) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (mptr + k) % NREQ;
        if (!found && req[j]) begin
          found   = 1'b1;
          m_id    = j;
          m_op    = int'(op[2*j +: 2]);
          if (m_op == 3) m_op = 0;
          m_addr  = addr[ADDR_W*j +: ADDR_W];
          m_data  = wdata[DATA_W*j +: DATA_W];
          m_start = cyc;
          m_act   = 1'b1;
          mptr    = (j + 1) % NREQ;
          m_oob   = 1'b0;
`ifdef GRID_ARB_BOUNDS_EN
          m_oob   = (int'(m_addr) >= GRID_CELLS);
`endif
          m_lat   = m_oob ? 1 : (m_op == 1 ? 2 : 4);
          m_rd    = m_oob ? '0 : gmem[m_addr];
          m_ok    = !m_oob && m_op == 2 && gmem[m_addr] == EMPTY;
        end
      end
    end
  endtask

  task automatic check();
    logic [NREQ-1:0] e_ack;
    bit live, e_re, e_we;
    live  = m_act && cyc > m_start && cyc <= m_start + m_lat;
    e_ack = (m_act && cyc == m_start + m_lat) ? (NREQ'(1) << m_id) : '0;
    e_re  = live && !m_oob && m_op != 1 && cyc == m_start + 1;
    e_we  = live && !m_oob && ((m_op == 1 && cyc == m_start + 1) ||
                               (m_op == 2 && m_ok && cyc == m_start + 3));
    chk("busy", busy, live);
    chk("ack", ack, e_ack);
    chk("mem_re", mem_re, e_re);
    chk("mem_we", mem_we, e_we);
    chk("strobe_excl", mem_re & mem_we, 0);
    if (e_re || e_we) chk("mem_addr", mem_addr, m_addr);
    if (e_we) chk("mem_wdata", mem_wdata, m_data);
    if (e_ack != '0) begin
      chk("claim_ok", claim_ok, m_ok);
      if (m_op != 1) chk("rdata", rdata, m_rd);
`ifdef GRID_ARB_BOUNDS_EN
      chk("err", err, m_oob);
`endif
      if (!m_oob && (m_op == 1 || m_ok)) gmem[m_addr] = m_data;
    end
    if (mem_we) we_cnt++;
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) begin
        ack_seen[i] = 1'b1;
        ack_cyc[i]  = cyc;
        ack_rd[i]   = rdata;
        ack_ok[i]   = claim_ok;
        gorder.push_back(i);
      end
    end
  endtask

  task automatic cycle();
    model_grant();
    @(negedge clk);
    cyc++;
    check();
    if (!hold_all)
      for (int i = 0; i < NREQ; i++)
        if (ack[i]) req[i] = 1'b0;
  endtask

  task automatic post(input int i, input logic [1:0] o, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    op[2*i +: 2]           = o;
    addr[ADDR_W*i +: ADDR_W] = a;
    wdata[DATA_W*i +: DATA_W] = d;
    req[i]                 = 1'b1;
    ack_seen[i]            = 1'b0;
  endtask

  task automatic wait_ack(input int i, input int bound);
    int n;
    n = 0;
    while (!ack_seen[i] && n < bound) begin
      cycle();
      n++;
    end
    chk($sformatf("ack_r%0d_seen", i), ack_seen[i], 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || req != '0) && n < 30) begin
      cycle();
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;

    // Reset state
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_claim_ok", claim_ok, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    repeat (3) cycle();
    reset = 1'b0;
    cycle();

    // Requester 0 WRITE addr 10 data 5
    we_cnt = 0;
    post(0, 2'd1, 6'd10, 32'd5);
    s = cyc;
    wait_ack(0, 20);
    chk("wr_latency", ack_cyc[0] - s, 2);
    chk("wr_claim_ok", ack_ok[0], 0);
    wait_idle();
    chk("wr_we_pulses", we_cnt, 1);
    chk("wr_ram10", ram[10], 32'd5);

    // Requester 1 READ addr 10
    post(1, 2'd0, 6'd10, 32'd0);
    s = cyc;
    wait_ack(1, 20);
    chk("rd_latency", ack_cyc[1] - s, 4);
    chk("rd_rdata", ack_rd[1], 32'd5);
    wait_idle();

    // Requesters 2 and 3 CLAIM addr 20 together
    post(2, 2'd2, 6'd20, 32'd7);
    post(3, 2'd2, 6'd20, 32'd9);
    s = cyc;
    wait_ack(2, 20);
    wait_ack(3, 20);
    chk("cl2_latency", ack_cyc[2] - s, 4);
    chk("cl2_ok", ack_ok[2], 1);
    chk("cl2_rdata", ack_rd[2], EMPTY);
    chk("cl3_ack_cycle", ack_cyc[3] - s, 9);
    chk("cl3_ok", ack_ok[3], 0);
    chk("cl3_rdata", ack_rd[3], 32'd7);
    wait_idle();
    chk("cl_ram20", ram[20], 32'd7);

    // All four hold READ requests; requester 3 uses the undefined opcode
    hold_all = 1'b1;
    gorder.delete();
    post(0, 2'd0, 6'd10, 32'd0);
    post(1, 2'd0, 6'd20, 32'd0);
    post(2, 2'd0, 6'd1, 32'd0);
    post(3, 2'd3, 6'd63, 32'h55);
    s = cyc;
    for (int n = 0; n < 60 && gorder.size() < 5; n++) cycle();
    req = '0;
    hold_all = 1'b0;
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr_order_%0d", k), (k < gorder.size()) ? gorder[k] : 99, k % 4);
    chk("rr_fifth_ack_cycle", ack_cyc[0] - s, 24);
    chk("rr_rdata_r0", ack_rd[0], 32'd5);
    chk("rr_rdata_r1", ack_rd[1], 32'd7);
    chk("rr_rdata_r3", ack_rd[3], EMPTY);
    chk("rr_ok_r3", ack_ok[3], 0);
    wait_idle();
    chk("rr_ram63", ram[63], EMPTY);

    // Inputs changed while a CLAIM is in flight
    post(1, 2'd2, 6'd30, 32'h1234);
    cycle();
    cycle();
    op[2 +: 2]       = 2'd0;
    addr[6 +: 6]     = 6'd31;
    wdata[32 +: 32]  = 32'hDEAD;
    wait_ack(1, 20);
    chk("mid_ok", ack_ok[1], 1);
    wait_idle();
    chk("mid_ram30", ram[30], 32'h1234);
    chk("mid_ram31", ram[31], EMPTY);

    // Reset during EVAL of a CLAIM on an empty cell
    post(0, 2'd2, 6'd40, 32'h77);
    s = cyc;
    while (cyc < s + 3) cycle();
    reset = 1'b1;
    req = '0;
    m_act = 1'b0;
    mptr = 0;
    #1;
    chk("abort_mem_we", mem_we, 0);
    chk("abort_ack", ack, 0);
    chk("abort_busy", busy, 0);
    chk("abort_claim_ok", claim_ok, 0);
    chk("abort_rdata", rdata, 0);
    repeat (3) cycle();
    reset = 1'b0;
    repeat (4) cycle();
    chk("abort_no_ack", ack_seen[0], 0);
    chk("abort_ram40", ram[40], EMPTY);

    // Pointer restarts at 0 after reset: requester 0 beats requester 3
    gorder.delete();
    post(0, 2'd0, 6'd10, 32'd0);
    post(3, 2'd0, 6'd40, 32'd0);
    wait_ack(0, 20);
    wait_ack(3, 20);
    chk("post_rst_first", (gorder.size() > 0) ? gorder[0] : 99, 0);
    chk("post_rst_rd0", ack_rd[0], 32'd5);
    chk("post_rst_rd3", ack_rd[3], EMPTY);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
